// File: rtl/data_inf_c_intc_m2s_rr_lazy.sv
// Round-robin merge of NUM valid/ready sources into one registered sink stream.
// Each output beat carries its lazy side-field and the index of the source that produced it.
module data_inf_c_intc_m2s_rr_lazy #(
    parameter int NUM    = 8,
    parameter int NSIZE  = $clog2(NUM),
    parameter int LAZISE = 1,
    parameter int DSIZE  = 8
) (
    input  logic                           clock,
    input  logic                           rst,
    input  logic [NUM-1:0]                 s00_valid,
    output logic [NUM-1:0]                 s00_ready,
    input  logic [NUM-1:0][DSIZE-1:0]      s00_data,
    input  logic [NUM-1:0][LAZISE-1:0]     s00_lazy_data,
    output logic                           m00_valid,
    input  logic                           m00_ready,
    output logic [DSIZE-1:0]               m00_data,
    output logic [LAZISE-1:0]              m00_lazy_data,
    output logic [NSIZE-1:0]               m00_addr
);

    logic              valid_q, valid_d;
    logic [DSIZE-1:0]  data_q, data_d;
    logic [LAZISE-1:0] lazy_q, lazy_d;
    logic [NSIZE-1:0]  addr_q, addr_d;
    logic [NSIZE-1:0]  last_grant_q, last_grant_d;

    logic              load;
    logic              any_valid;
    logic [NSIZE-1:0]  grant;
    logic [NSIZE-1:0]  cand;
    int                sum;

    assign load = !valid_q || m00_ready;

    // Candidates start one past the last winner and wrap modulo NUM, so a
    // non-power-of-two NUM never selects a nonexistent port.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        any_valid = 1'b0;
        grant     = '0;
        cand      = '0;
        sum       = 0;
        for (int k = 1; k <= NUM; k++) begin
            sum = int'(last_grant_q) + k;
            if (sum >= NUM) begin
                sum = sum - NUM;
            end
            cand = NSIZE'(sum);
            if (!any_valid && s00_valid[cand]) begin
                any_valid = 1'b1;
                grant     = cand;
            end
        end
    end

    always_comb begin
        s00_ready = '0;
        if (load && any_valid && !rst) begin
            s00_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        lazy_d       = lazy_q;
        addr_d       = addr_q;
        last_grant_d = last_grant_q;
        if (load) begin
            valid_d = any_valid;
            if (any_valid) begin
                data_d       = s00_data[grant];
                lazy_d       = s00_lazy_data[grant];
                addr_d       = grant;
                last_grant_d = grant;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            data_q       <= '0;
            lazy_q       <= '0;
            addr_q       <= '0;
            last_grant_q <= NSIZE'(NUM - 1);
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            lazy_q       <= lazy_d;
            addr_q       <= addr_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign m00_valid     = valid_q;
    assign m00_data      = data_q;
    assign m00_lazy_data = lazy_q;
    assign m00_addr      = addr_q;

endmodule
